// File: rtl/sha_mem_responder.sv
// sha_mem_responder
//
// Word-addressed 32-bit memory sitting on the SHA-256 engine's memory port.
// The engine reads message words and writes the digest through its port. A
// second host port preloads the message and reads back the digest.
// Optional sequential zero-fill of the array. Bring-up counters and a sticky
// out-of-range flag.
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   mem_we, mem_addr,    engine port, active every cycle (read when mem_we=0)
//   mem_write_data,
//   mem_read_data        registered engine read data, held on write cycles
//   host_en, host_we,    host port, acts only when host_en=1
//   host_addr,
//   host_write_data,
//   host_read_data,      registered host read data
//   host_rvalid          pulses with host_read_data for each host read
//   clr_mem, busy        start zero-fill (INIT_ZERO=1 only) / fill in progress
//   clr_counts           synchronous zeroing of rd_count and wr_count
//   rd_count, wr_count   saturating engine read/write counters
//   addr_err             sticky flag for any out-of-range access
module sha_mem_responder #(
  parameter int DEPTH     = 1024,
  parameter int INIT_ZERO = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        host_en,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_write_data,
  output logic [31:0] host_read_data,
  output logic        host_rvalid,
  input  logic        clr_mem,
  output logic        busy,
  input  logic        clr_counts,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        addr_err
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [16:0]     DEPTH_W   = 17'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t    state, next_state;
  logic [AW-1:0] clr_ptr;
  logic [31:0]   mem [DEPTH];

  logic          eng_in_range;
  logic          host_in_range;
  logic          clearing;
  logic          host_active;
  logic          host_read;
  logic [AW-1:0] eng_idx;
  logic [AW-1:0] host_idx;

  // The compare is done one bit wider so DEPTH=65536 still works.
  assign eng_in_range  = ({1'b0, mem_addr} < DEPTH_W);
  assign host_in_range = ({1'b0, host_addr} < DEPTH_W);
  assign eng_idx       = mem_addr[AW-1:0];
  assign host_idx      = host_addr[AW-1:0];

  // The host port is shut off completely while the zero-fill runs.
  assign clearing    = (state == CLEAR);
  assign host_active = host_en && !clearing;
  assign host_read   = host_active && !host_we;
  assign busy        = clearing;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clr_mem && (INIT_ZERO != 0)) next_state = CLEAR;
      CLEAR:   if (clr_ptr == LAST_ADDR) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_ptr <= '0;
    end else begin
      state <= next_state;
      if (clearing) clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + AW'(1);
    end
  end

  // The array is not reset. Later assignments win, so the write order below
  // gives the priority: clear, then host, then engine.
  always_ff @(posedge clk) begin
    if (clearing) mem[clr_ptr] <= '0;
    if (host_active && host_we && host_in_range) mem[host_idx] <= host_write_data;
    if (mem_we && eng_in_range) mem[eng_idx] <= mem_write_data;
  end

  // Reads sample the array before this edge's writes land (read-before-write).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data  <= '0;
      host_read_data <= '0;
      host_rvalid    <= 1'b0;
    end else begin
      if (!mem_we) mem_read_data <= eng_in_range ? mem[eng_idx] : '0;
      host_rvalid <= host_read;
      if (host_read) host_read_data <= host_in_range ? mem[host_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_err <= 1'b0;
    end else if (!eng_in_range || (host_active && !host_in_range)) begin
      addr_err <= 1'b1;
    end
  end

  // Out-of-range accesses still count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (clr_counts) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (mem_we) begin
      if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end else begin
      if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sha_mem_responder.sv
// tb_sha_mem_responder
//
// Directed bench for sha_mem_responder. There are two instances that share
// all inputs. The default instance (DEPTH=1024, no clear) covers the main
// access paths and the out-of-range handling. A DEPTH=64 INIT_ZERO=1
// instance covers the zero-fill.
module tb_sha_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        host_en;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_write_data;
  logic        clr_mem;
  logic        clr_counts;

  logic [31:0] a_mem_read_data, a_host_read_data;
  logic        a_host_rvalid, a_busy, a_addr_err;
  logic [15:0] a_rd_count, a_wr_count;

  logic [31:0] b_mem_read_data, b_host_read_data;
  logic        b_host_rvalid, b_busy, b_addr_err;
  logic [15:0] b_rd_count, b_wr_count;

  int num_checks = 0;
  int num_fails  = 0;

  always #5 clk = ~clk;

  sha_mem_responder #(.DEPTH(1024), .INIT_ZERO(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(a_mem_read_data),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_write_data(host_write_data), .host_read_data(a_host_read_data),
    .host_rvalid(a_host_rvalid), .clr_mem(clr_mem), .busy(a_busy),
    .clr_counts(clr_counts), .rd_count(a_rd_count), .wr_count(a_wr_count),
    .addr_err(a_addr_err)
  );

  sha_mem_responder #(.DEPTH(64), .INIT_ZERO(1)) dut_clr (
    .clk(clk), .reset_n(reset_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(b_mem_read_data),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_write_data(host_write_data), .host_read_data(b_host_read_data),
    .host_rvalid(b_host_rvalid), .clr_mem(clr_mem), .busy(b_busy),
    .clr_counts(clr_counts), .rd_count(b_rd_count), .wr_count(b_wr_count),
    .addr_err(b_addr_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle on both ports, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic e_we, input logic [15:0] e_addr,
                               input logic [31:0] e_wdata, input logic h_en,
                               input logic h_we, input logic [15:0] h_addr,
                               input logic [31:0] h_wdata);
    mem_we          = e_we;
    mem_addr        = e_addr;
    mem_write_data  = e_wdata;
    host_en         = h_en;
    host_we         = h_we;
    host_addr       = h_addr;
    host_write_data = h_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles;
    int rvalid_seen;

    reset_n    = 1'b1;
    clr_mem    = 1'b0;
    clr_counts = 1'b1;
    mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
    host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_write_data = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst_mem_read_data", a_mem_read_data, 32'h0);
    checkOutput("rst_host_read_data", a_host_read_data, 32'h0);
    checkOutput("rst_host_rvalid", 32'(a_host_rvalid), 32'h0);
    checkOutput("rst_busy", 32'(b_busy), 32'h0);
    checkOutput("rst_addr_err", 32'(a_addr_err), 32'h0);
    checkOutput("rst_rd_count", 32'(a_rd_count), 32'h0);
    checkOutput("rst_wr_count", 32'(a_wr_count), 32'h0);
    reset_n = 1'b1;

    $display("[TB] preload and engine reads");
    for (int n = 0; n < 20; n++)
      applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'(n), 32'h11111111 + 32'(4 * n));
    clr_counts = 1'b0;
    applyStimulus(1'b0, 16'd5, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("eng_read_5", a_mem_read_data, 32'h11111125);
    checkOutput("rd_count_1", 32'(a_rd_count), 32'h1);
    checkOutput("no_host_rvalid", 32'(a_host_rvalid), 32'h0);
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("b2b_read_0", a_mem_read_data, 32'h11111111);
    applyStimulus(1'b0, 16'd1, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("b2b_read_1", a_mem_read_data, 32'h11111115);
    applyStimulus(1'b0, 16'd2, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("b2b_read_2", a_mem_read_data, 32'h11111119);
    checkOutput("rd_count_4", 32'(a_rd_count), 32'h4);

    applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd7, 32'h0);
    checkOutput("host_read_7", a_host_read_data, 32'h1111112D);
    checkOutput("host_rvalid_1", 32'(a_host_rvalid), 32'h1);
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("host_rvalid_drop", 32'(a_host_rvalid), 32'h0);
    checkOutput("host_data_hold", a_host_read_data, 32'h1111112D);

    $display("[TB] collisions");
    applyStimulus(1'b1, 16'd32, 32'hDEADBEEF, 1'b1, 1'b1, 16'd32, 32'h0);
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd32, 32'h0);
    checkOutput("ww_engine_wins", a_host_read_data, 32'hDEADBEEF);
    checkOutput("eng_read_0", a_mem_read_data, 32'h11111111);
    applyStimulus(1'b1, 16'd32, 32'hCAFEF00D, 1'b1, 1'b0, 16'd32, 32'h0);
    checkOutput("host_rbw_old", a_host_read_data, 32'hDEADBEEF);
    checkOutput("eng_hold_on_write", a_mem_read_data, 32'h11111111);
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd32, 32'h0);
    checkOutput("host_read_new", a_host_read_data, 32'hCAFEF00D);
    checkOutput("wr_count_2", 32'(a_wr_count), 32'h2);
    applyStimulus(1'b0, 16'd4, 32'h0, 1'b1, 1'b1, 16'd4, 32'h55555555);
    checkOutput("eng_rbw_old", a_mem_read_data, 32'h11111121);
    applyStimulus(1'b0, 16'd4, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("eng_rbw_new", a_mem_read_data, 32'h55555555);

    $display("[TB] out of range");
    clr_counts = 1'b1;
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    clr_counts = 1'b0;
    checkOutput("clr_counts_rd", 32'(a_rd_count), 32'h0);
    checkOutput("addr_err_clean", 32'(a_addr_err), 32'h0);
    applyStimulus(1'b1, 16'd1024, 32'h12345678, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("oor_wr_count", 32'(a_wr_count), 32'h1);
    checkOutput("oor_addr_err", 32'(a_addr_err), 32'h1);
    applyStimulus(1'b0, 16'd1024, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("oor_read_zero", a_mem_read_data, 32'h0);
    checkOutput("oor_rd_count", 32'(a_rd_count), 32'h1);
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'd2000, 32'h0);
    checkOutput("oor_addr0_intact", a_mem_read_data, 32'h11111111);
    checkOutput("oor_host_zero", a_host_read_data, 32'h0);
    checkOutput("addr_err_sticky", 32'(a_addr_err), 32'h1);

    $display("[TB] full clear");
    clr_mem = 1'b1;
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    clr_mem = 1'b0;
    checkOutput("busy_rise", 32'(b_busy), 32'h1);
    checkOutput("no_clear_default", 32'(a_busy), 32'h0);
    busy_cycles = 1;
    rvalid_seen = 0;
    for (int i = 1; i <= 64; i++) begin
      if (i == 41) applyStimulus(1'b1, 16'd40, 32'hA5A5A5A5, 1'b1, 1'b0, 16'(i % 64), 32'h0);
      else         applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'(i % 64), 32'h0);
      busy_cycles += int'(b_busy);
      rvalid_seen += int'(b_host_rvalid);
    end
    checkOutput("busy_cycles", 32'(busy_cycles), 32'd64);
    checkOutput("clear_host_ignored", 32'(rvalid_seen), 32'd0);
    checkOutput("busy_fall", 32'(b_busy), 32'h0);
    for (int n = 0; n < 64; n++) begin
      applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'(n), 32'h0);
      checkOutput($sformatf("cleared_%0d", n), b_host_read_data,
                  (n == 40) ? 32'hA5A5A5A5 : 32'h0);
    end
    checkOutput("post_clear_rvalid", 32'(b_host_rvalid), 32'h1);

    $display("[TB] clear aborted by reset");
    for (int n = 0; n < 20; n++)
      applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b1, 16'(n), 32'h11111111 + 32'(4 * n));
    clr_mem = 1'b1;
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    clr_mem = 1'b0;
    repeat (10) applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy_low", 32'(b_busy), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, 16'(n), 32'h0);
      checkOutput($sformatf("abort_word_%0d", n), b_host_read_data,
                  (n < 10) ? 32'h0 : 32'h11111111 + 32'(4 * n));
    end
    checkOutput("abort_stays_idle", 32'(b_busy), 32'h0);

    $display("[TB] counter saturation");
    mem_we = 1'b0; mem_addr = 16'd0; host_en = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("rd_count_sat", 32'(a_rd_count), 32'hFFFF);
    checkOutput("wr_count_idle", 32'(a_wr_count), 32'h0);
    clr_counts = 1'b1;
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    clr_counts = 1'b0;
    checkOutput("clr_over_inc", 32'(a_rd_count), 32'h0);
    applyStimulus(1'b0, 16'd0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0);
    checkOutput("count_restart", 32'(a_rd_count), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/sha_mem_responder.md
# sha_mem_responder

Word-addressed synchronous memory that answers the SHA-256 engine's memory requests: it supplies message words on reads and stores the digest on writes. A second host port preloads the message and reads back the digest. The engine's memory port connects here directly, and the engine's `mem_clk` equals `clk`. The block also keeps access counters and a sticky out-of-range error flag for bring-up and verification.

## Interface
Parameters:
- `DEPTH`, default 1024: number of 32-bit words; valid addresses are 0..DEPTH-1; range 2..65536.
- `INIT_ZERO`, default 0: when 1, a `clr_mem` pulse zeroes the array one word per cycle.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_we` in 1: engine write enable; 0 means a read request.
- `mem_addr` in 16: engine word address.
- `mem_write_data` in 32: engine write data.
- `mem_read_data` out 32: engine read data, registered.
- `host_en` in 1: host access request this cycle.
- `host_we` in 1: host write when `host_en`=1.
- `host_addr` in 16: host word address.
- `host_write_data` in 32: host write data.
- `host_read_data` out 32: host read data, registered.
- `host_rvalid` out 1: `host_read_data` is valid for the previous cycle's host read.
- `clr_mem` in 1: start array clear (used only when INIT_ZERO=1).
- `busy` out 1: clear in progress.
- `clr_counts` in 1: synchronous zeroing of both counters.
- `rd_count` out 16: engine reads served, saturating at 16'hFFFF.
- `wr_count` out 16: engine writes accepted, saturating at 16'hFFFF.
- `addr_err` out 1: sticky; set by any out-of-range access on either port.

## Operation
- The engine port is always active. Every cycle is a read (`mem_we`=0) or a write (`mem_we`=1); there is no enable signal.
- Engine read:
  - Address sampled at edge k.
  - `mem_read_data` is updated at edge k and is stable through edge k+1, where the engine captures it.
  - `mem_read_data` holds its value on engine write cycles.
- Engine write: the array word is updated at the sampling edge.
- Host port:
  - Acts only when `host_en`=1.
  - Read data and `host_rvalid`=1 are registered at the same edge.
  - `host_rvalid` is 0 on every other cycle.
- Same-address collisions in one cycle:
  - Both ports write: the engine data wins.
  - One port writes, the other reads: the reader gets the old contents (read-before-write).
- Out-of-range address (addr >= DEPTH):
  - Writes are ignored.
  - Reads return 32'h0.
  - `addr_err` is set and stays set until reset.
  - The access still counts in `rd_count`/`wr_count`.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when `clr_mem`=1 and INIT_ZERO=1.
  - CLEAR writes 0 to address `clr_ptr`, which increments from 0.
  - CLEAR -> IDLE after writing DEPTH-1.
  - `busy`=1 in CLEAR.
  - During CLEAR the host port is ignored (`host_rvalid` stays 0).
  - Engine writes during CLEAR take priority over the clear write at the same address.
  - `clr_mem` is ignored while in CLEAR.
- Counters:
  - Increment by 1 per engine cycle of the matching type and saturate.
  - `clr_counts` overrides any increment in the same cycle.

## Timing
- Reset values: `mem_read_data`=0, `host_read_data`=0, `host_rvalid`=0, `busy`=0, `addr_err`=0, `rd_count`=0, `wr_count`=0, FSM=IDLE, `clr_ptr`=0.
- The array is not reset.
- Read latency is 1 cycle on both ports. Throughput is one access per port per cycle.
- Clear takes DEPTH cycles: `busy` rises the edge after `clr_mem` is sampled and falls DEPTH edges later.
- Reset asserted mid-clear: FSM returns to IDLE immediately. Words already cleared stay cleared; the rest keep their old contents.

## Test plan
- Preload: host writes 0x11111111 + 4·n to addresses 0..19, then the engine reads address 5 with `mem_we`=0 -> `mem_read_data`=0x11111125 one edge later, `rd_count`=1.
- Back-to-back engine reads of addresses 0,1,2 on consecutive cycles -> data 0x11111111, 0x11111115, 0x11111119 on consecutive cycles, no bubbles.
- Collision:
  - Engine writes 0xDEADBEEF and host writes 0x0 to address 32 in the same cycle -> host read of 32 returns 0xDEADBEEF.
  - Host reads 32 while the engine writes 0xCAFEF00D -> host gets 0xDEADBEEF, next read returns 0xCAFEF00D.
- Out of range (DEPTH=1024): engine writes 0x12345678 to 1024, then reads 1024 -> read returns 0, `addr_err`=1 until reset, `wr_count`=1, `rd_count`=1, address 0 unchanged.
- Clear with INIT_ZERO=1, DEPTH=64: pulse `clr_mem` -> `busy` high for exactly 64 cycles and host requests produce no `host_rvalid`; afterwards all words read 0. A repeat run with `reset_n` low at clear cycle 10 -> addresses 0..9 read 0, address 10 and above keep their prior data, `busy`=0.
- Counter saturation: force 65540 engine reads -> `rd_count`=16'hFFFF. Then `clr_counts` asserted together with a read -> `rd_count`=0.
